// File: rtl/desc_frame_tracker.sv
// Descriptor-to-frame-set tracker.
// Attributes detector descriptors to the image channel currently being
// captured, hands out per-channel store addresses and keeps a ring of
// per-channel descriptor counts for the last HIST_DEPTH completed frame sets.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   img_valid   high during one channel's pixel burst
//   feat_valid  one qualified descriptor from the detector pipeline
//   wr_en       descriptor store write enable (combinational)
//   wr_ch       channel of the write (combinational)
//   wr_addr     write address = channel count before increment (combinational)
//   set_start   first cycle of a channel-0 burst (combinational)
//   set_done    registered pulse, cycle after the last-channel burst ends
//   cur_ch      registered channel currently being attributed
//   ovf         registered sticky saturation flag for the open set
//   hist_sel    history select, 0 = most recent completed set
//   hist_ch     channel of the history read
//   hist_cnt    committed count (combinational read)
//   hist_vld    selected history slot holds a committed set (combinational)
//
// Build option: define DESC_SAT_EN to saturate the channel counters at
// 2^CNT_W-1 (further writes dropped, ovf raised); otherwise counters wrap.
module desc_frame_tracker #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned HIST_DEPTH = 3,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned HS_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             img_valid,
  input  logic             feat_valid,
  output logic             wr_en,
  output logic [CH_W-1:0]  wr_ch,
  output logic [CNT_W-1:0] wr_addr,
  output logic             set_start,
  output logic             set_done,
  output logic [CH_W-1:0]  cur_ch,
  output logic             ovf,
  input  logic [HS_W-1:0]  hist_sel,
  input  logic [CH_W-1:0]  hist_ch,
  output logic [CNT_W-1:0] hist_cnt,
  output logic             hist_vld
);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t           state, state_nxt;
  logic             armed;
  logic [CNT_W-1:0] cnt     [NUM_CH];
  logic [CNT_W-1:0] cnt_upd [NUM_CH];
  logic [CNT_W-1:0] hist    [HIST_DEPTH][NUM_CH];
  logic [HS_W-1:0]  wptr;
  logic [HS_W:0]    ncommit;
  logic [HS_W:0]    rd_idx;
  logic [CNT_W-1:0] cur_cnt;
  logic             start, last_ch, blocked, attrib, commit;

  // Burst detection, attribution and counter next values
  always_comb begin
    last_ch = (cur_ch == CH_W'(NUM_CH - 1));
    // armed keeps a burst already in progress at reset release from starting a set
    start     = img_valid && (state != BURST) && ((state != IDLE) || armed);
    set_start = start && ((state == IDLE) || last_ch);
    commit    = set_start && (state == GAP);
    attrib    = feat_valid && (state != IDLE);
    cur_cnt   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cur_ch == CH_W'(c)) cur_cnt = cnt[c];
    end
`ifdef DESC_SAT_EN
    blocked = &cur_cnt;
`else
    blocked = 1'b0;
`endif
    wr_en   = attrib && !blocked;
    wr_ch   = cur_ch;
    wr_addr = cur_cnt;
    // Includes a write issued on the set_start cycle, so the commit sees it
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_upd[c] = cnt[c] + CNT_W'(wr_en && (cur_ch == CH_W'(c)));
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BURST;
      BURST:   if (!img_valid) state_nxt = GAP;
      GAP:     if (start) state_nxt = BURST;
      default: state_nxt = IDLE;
    endcase
  end

  // State, channel, counters and history bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      armed    <= 1'b0;
      cur_ch   <= '0;
      ovf      <= 1'b0;
      set_done <= 1'b0;
      wptr     <= '0;
      ncommit  <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
    end else begin
      state    <= state_nxt;
      set_done <= (state == BURST) && !img_valid && last_ch;
      if (!img_valid) armed <= 1'b1;
      if (set_start) begin
        cur_ch <= '0;
        ovf    <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      end else begin
        if (start) cur_ch <= cur_ch + CH_W'(1);
        if (attrib && blocked) ovf <= 1'b1;
        for (int c = 0; c < NUM_CH; c++) cnt[c] <= cnt_upd[c];
      end
      if (commit) begin
        wptr <= (wptr == HS_W'(HIST_DEPTH - 1)) ? '0 : wptr + HS_W'(1);
        if (ncommit != (HS_W+1)'(HIST_DEPTH)) ncommit <= ncommit + (HS_W+1)'(1);
      end
    end
  end

  // History ring storage; slots change only on commit, validity tracked by ncommit
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int h = 0; h < HIST_DEPTH; h++) begin
        if (wptr == HS_W'(h)) begin
          for (int c = 0; c < NUM_CH; c++) hist[h][c] <= cnt_upd[c];
        end
      end
    end
  end

  // History read: slot = (wptr - 1 - hist_sel) mod HIST_DEPTH
  always_comb begin
    hist_vld = ({1'b0, hist_sel} < ncommit);
    if ({1'b0, wptr} > {1'b0, hist_sel})
      rd_idx = {1'b0, wptr} - (HS_W+1)'(1) - {1'b0, hist_sel};
    else
      rd_idx = {1'b0, wptr} + (HS_W+1)'(HIST_DEPTH - 1) - {1'b0, hist_sel};
    hist_cnt = '0;
    for (int h = 0; h < HIST_DEPTH; h++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hist_vld && (rd_idx == (HS_W+1)'(h)) && (hist_ch == CH_W'(c)))
          hist_cnt = hist[h][c];
      end
    end
  end

endmodule

// File: tb/tb_desc_frame_tracker.sv
// Self-checking bench for desc_frame_tracker at default parameters.
module tb_desc_frame_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       img_valid, feat_valid;
  logic       wr_en, set_start, set_done, ovf, hist_vld;
  logic       wr_ch, cur_ch, hist_ch;
  logic [9:0] wr_addr, hist_cnt;
  logic [1:0] hist_sel;

  int total = 0;
  int bad   = 0;

  desc_frame_tracker dut (
    .clk(clk), .rst(rst), .img_valid(img_valid), .feat_valid(feat_valid),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .set_start(set_start),
    .set_done(set_done), .cur_ch(cur_ch), .ovf(ovf), .hist_sel(hist_sel),
    .hist_ch(hist_ch), .hist_cnt(hist_cnt), .hist_vld(hist_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    int img, feat, sel, hch;
    int we, wch, addr, ss, sd, cc, hv, hc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs mid-cycle; outputs are then sampled 1ns later
  task automatic step(input int img, input int feat);
    @(negedge clk);
    img_valid  = (img != 0);
    feat_valid = (feat != 0);
    #1;
  endtask

  task automatic hist_chk(input string name, input int sel, input int ch,
                          input int exp_v, input int exp_c);
    hist_sel = 2'(sel);
    hist_ch  = 1'(ch);
    #1;
    chk({name, "_vld"}, int'(hist_vld), exp_v);
    chk({name, "_cnt"}, int'(hist_cnt), exp_c);
  endtask

  // One burst on channel ch with n features at cycles 2,7,12,...
  task automatic burst(input int ch, input int n, input int blen, input int exp_ss);
    for (int i = 0; i < blen; i++) begin
      int f;
      f = ((i % 5) == 2 && (i / 5) < n) ? 1 : 0;
      step(1, f);
      if (i == 0) chk("burst_set_start", int'(set_start), exp_ss);
      if (i == 1) chk("burst_cur_ch", int'(cur_ch), ch);
      if (f != 0) begin
        chk("burst_wr_en", int'(wr_en), 1);
        chk("burst_wr_ch", int'(wr_ch), ch);
        chk("burst_wr_addr", int'(wr_addr), i / 5);
      end
    end
  endtask

  task automatic gap(input int ch);
    for (int j = 0; j < 4; j++) begin
      step(0, 0);
      if (j == 1) chk("gap_set_done", int'(set_done), (ch == 1) ? 1 : 0);
    end
  endtask

  task automatic run_set(input int n0, input int n1);
    burst(0, n0, 50, 1);
    gap(0);
    burst(1, n1, 50, 0);
    gap(1);
  endtask

  task automatic do_reset(input int img);
    @(negedge clk);
    rst        = 1'b1;
    img_valid  = (img != 0);
    feat_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; img_valid = 1'b0; feat_valid = 1'b0;
    hist_sel = '0; hist_ch = '0;

    //          img feat sel hch  we wch addr ss sd cc hv hc
    vecs[0]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 1, 0, 0,  1, 0, 2, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 0, 0, 0,  0, 0, 3, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 1, 0, 0,  1, 1, 0, 0, 0, 1, 0, 0};
    vecs[8]  = '{1, 1, 0, 0,  1, 1, 1, 0, 0, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 0,  0, 1, 2, 0, 0, 1, 0, 0};
    vecs[10] = '{0, 0, 0, 0,  0, 1, 2, 0, 1, 1, 0, 0};
    vecs[11] = '{0, 1, 0, 0,  1, 1, 2, 0, 0, 1, 0, 0};
    vecs[12] = '{1, 1, 0, 0,  1, 1, 3, 1, 0, 1, 0, 0};
    vecs[13] = '{1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 3};
    vecs[14] = '{1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1, 4};
    vecs[15] = '{1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{1, 0, 2, 1,  0, 0, 0, 0, 0, 0, 0, 0};

    // Reset with a burst in progress; it must not open a set
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1);
      chk("rst_burst_set_start", int'(set_start), 0);
      chk("rst_burst_wr_en", int'(wr_en), 0);
      chk("rst_burst_cur_ch", int'(cur_ch), 0);
      chk("rst_ovf", int'(ovf), 0);
    end

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      img_valid  = (vecs[i].img != 0);
      feat_valid = (vecs[i].feat != 0);
      hist_sel   = 2'(vecs[i].sel);
      hist_ch    = 1'(vecs[i].hch);
      #1;
      chk($sformatf("vec%0d_wr_en", i), int'(wr_en), vecs[i].we);
      chk($sformatf("vec%0d_wr_ch", i), int'(wr_ch), vecs[i].wch);
      chk($sformatf("vec%0d_wr_addr", i), int'(wr_addr), vecs[i].addr);
      chk($sformatf("vec%0d_set_start", i), int'(set_start), vecs[i].ss);
      chk($sformatf("vec%0d_set_done", i), int'(set_done), vecs[i].sd);
      chk($sformatf("vec%0d_cur_ch", i), int'(cur_ch), vecs[i].cc);
      chk($sformatf("vec%0d_ovf", i), int'(ovf), 0);
      chk($sformatf("vec%0d_hist_vld", i), int'(hist_vld), vecs[i].hv);
      chk($sformatf("vec%0d_hist_cnt", i), int'(hist_cnt), vecs[i].hc);
    end

    // Reset mid-burst with history present: history invalidated, no start until low
    do_reset(1);
    for (int i = 0; i < 2; i++) begin
      step(1, 0);
      chk("rst2_set_start", int'(set_start), 0);
    end
    for (int s = 0; s < 4; s++) hist_chk($sformatf("rst2_sel%0d", s), s, 0, 0, 0);
    hist_sel = '0; hist_ch = '0;
    step(0, 0);

    // 50-cycle bursts, then ring wrap across five committed sets
    run_set(3, 5);
    run_set(1, 0);
    hist_chk("set1_ch0", 0, 0, 1, 3);
    hist_chk("set1_ch1", 0, 1, 1, 5);
    hist_chk("set1_prev", 1, 0, 0, 0);
    run_set(2, 0);
    run_set(3, 0);
    run_set(4, 0);
    step(1, 0);
    chk("set6_set_start", int'(set_start), 1);
    step(1, 0);
    hist_chk("ring_sel0", 0, 0, 1, 4);
    hist_chk("ring_sel1", 1, 0, 1, 3);
    hist_chk("ring_sel2", 2, 0, 1, 2);
    hist_chk("ring_sel3", 3, 0, 0, 0);

    // Counter limit: 1027 features on ch0
    do_reset(0);
    hist_sel = '0; hist_ch = '0;
    step(0, 0);
    for (int i = 0; i < 1030; i++) begin
      int k;
      k = i - 1;
      step(1, (i >= 1 && i <= 1027) ? 1 : 0);
      if (k == 0 || k == 1022 || k == 1023 || k == 1024 || k == 1026) begin
`ifdef DESC_SAT_EN
        chk($sformatf("lim%0d_wr_en", k), int'(wr_en), (k < 1023) ? 1 : 0);
        chk($sformatf("lim%0d_wr_addr", k), int'(wr_addr), (k < 1023) ? k : 1023);
`else
        chk($sformatf("lim%0d_wr_en", k), int'(wr_en), 1);
        chk($sformatf("lim%0d_wr_addr", k), int'(wr_addr), k % 1024);
`endif
      end
    end
    gap(0);
`ifdef DESC_SAT_EN
    chk("lim_ovf", int'(ovf), 1);
`else
    chk("lim_ovf", int'(ovf), 0);
`endif
    burst(1, 0, 3, 0);
    gap(1);
    step(1, 0);
    chk("lim_set_start", int'(set_start), 1);
    step(1, 0);
    chk("lim_ovf_cleared", int'(ovf), 0);
`ifdef DESC_SAT_EN
    hist_chk("lim_hist", 0, 0, 1, 1023);
`else
    hist_chk("lim_hist", 0, 0, 1, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
